// File: rtl/systolic_array_neg_chain_ctrl_pkg.sv
// Shared types for the optical-flow systolic array controllers.
package systolic_array_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned SHAMT_NBITS = 3;

   typedef struct packed {
      logic [SHAMT_NBITS-1:0] shamt1;
      logic [SHAMT_NBITS-1:0] shamt2;
   } shamt_pair_t;

endpackage

// File: rtl/systolic_array_neg_chain_ctrl_outq.sv
// Synchronous result FIFO: val/rdy on both sides, output read straight from storage
// registers (no enqueue-to-dequeue bypass), occupancy exported for credit tracking.
module systolic_array_neg_chain_outq
   import systolic_array_pkg::*;
#(
   parameter int unsigned p_depth = 16,
   parameter int unsigned p_width = 32
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_enq_val,
   output logic                           o_enq_rdy,
   input  logic [p_width-1:0]             i_enq_msg,
   output logic                           o_deq_val,
   input  logic                           i_deq_rdy,
   output logic [p_width-1:0]             o_deq_msg,
   output logic [$clog2(p_depth+1)-1:0]   o_occupancy
);

   localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int unsigned CntW = $clog2(p_depth + 1);

   logic [p_width-1:0] r_mem [p_depth];
   logic [PtrW-1:0]    r_wr_ptr;
   logic [PtrW-1:0]    r_rd_ptr;
   logic [CntW-1:0]    r_count;
   logic               w_enq;
   logic               w_deq;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(p_depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_enq_rdy   = (r_count != CntW'(p_depth));
   assign o_deq_val   = (r_count != '0);
   assign o_deq_msg   = r_mem[r_rd_ptr];
   assign o_occupancy = r_count;
   assign w_enq       = i_enq_val && o_enq_rdy;
   assign w_deq       = o_deq_val && i_deq_rdy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_mem[r_wr_ptr] <= i_enq_msg;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_deq) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CntW'(w_enq) - CntW'(w_deq);
      end
   end

endmodule

// File: rtl/systolic_array_neg_chain_ctrl.sv
// Sequencer for a chain of NegPE elements: holds per-PE shift amounts, injects a frame
// of samples, and collects chain results through a credit-protected output queue.
module systolic_array_neg_chain_ctrl
   import systolic_array_pkg::*;
#(
   parameter int unsigned data_width    = 32,
   parameter int unsigned p_shamt_nbits = 3,
   parameter int unsigned p_num_pes     = 4,
   parameter int unsigned p_chain_lat   = 8,
   parameter int unsigned p_out_depth   = 16,
   parameter int unsigned p_len_nbits   = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cfg_val,
   output logic                                 cfg_rdy,
   input  logic [$clog2(p_num_pes):0]           cfg_idx,
   input  logic [p_shamt_nbits-1:0]             cfg_shamt1,
   input  logic [p_shamt_nbits-1:0]             cfg_shamt2,
   input  logic                                 go_val,
   output logic                                 go_rdy,
   input  logic [p_len_nbits-1:0]               go_len,
   input  logic                                 in_val,
   output logic                                 in_rdy,
   input  logic [data_width-1:0]                in_msg,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   output logic [data_width-1:0]                out_msg,
   output logic                                 done,
   output logic [data_width-1:0]                chain_x,
   output logic [data_width-1:0]                chain_y,
   input  logic [data_width-1:0]                chain_y_res,
   output logic [p_num_pes*p_shamt_nbits-1:0]   shamt1_vec,
   output logic [p_num_pes*p_shamt_nbits-1:0]   shamt2_vec
);

   localparam int unsigned CredW = $clog2(p_out_depth + 1);
   localparam int unsigned VecW  = p_num_pes * p_shamt_nbits;

   state_t                  r_state;
   logic [p_len_nbits-1:0]  r_remaining;
   logic [CredW-1:0]        r_credits;
   logic [p_chain_lat:0]    r_vpipe;
   logic [data_width-1:0]   r_chain_x;
   logic [data_width-1:0]   r_chain_y;
   logic [VecW-1:0]         r_shamt1_vec;
   logic [VecW-1:0]         r_shamt2_vec;

   logic                    w_cfg_fire;
   logic                    w_go_fire;
   logic                    w_in_fire;
   logic                    w_out_fire;
   logic                    w_done;
   logic                    w_enq_rdy;
   logic [CredW-1:0]        w_occupancy;

   // Ready signals come only from registers so no val->rdy loop forms outside.
   assign cfg_rdy    = (r_state == IDLE);
   assign go_rdy     = (r_state == IDLE);
   assign in_rdy     = (r_state == RUN) && (r_remaining != '0) &&
                       (r_credits < CredW'(p_out_depth));
   assign w_done     = (r_state == DRAIN) && (r_vpipe == '0) && (w_occupancy == '0);
   assign done       = w_done;

   assign w_cfg_fire = cfg_val && cfg_rdy;
   assign w_go_fire  = go_val && go_rdy;
   assign w_in_fire  = in_val && in_rdy;
   assign w_out_fire = out_val && out_rdy;

   assign chain_x    = r_chain_x;
   assign chain_y    = r_chain_y;
   assign shamt1_vec = r_shamt1_vec;
   assign shamt2_vec = r_shamt2_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go_fire) begin
                  r_remaining <= go_len;
                  r_state     <= (go_len == '0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (w_in_fire) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == p_len_nbits'(1)) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_done) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Credits count queued plus in-flight results; the PEs cannot stall, so admission
   // is the only place back-pressure can act.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_credits <= '0;
         r_vpipe   <= '0;
         r_chain_x <= '0;
         r_chain_y <= '0;
      end else begin
         case ({w_in_fire, w_out_fire})
            2'b10:   r_credits <= r_credits + 1'b1;
            2'b01:   r_credits <= r_credits - 1'b1;
            default: ;
         endcase
         r_vpipe   <= {r_vpipe[p_chain_lat-1:0], w_in_fire};
         r_chain_x <= w_in_fire ? in_msg : '0;
         r_chain_y <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shamt1_vec <= '0;
         r_shamt2_vec <= '0;
      end else begin
         for (int i = 0; i < int'(p_num_pes); i++) begin
            if (w_cfg_fire && (int'(cfg_idx) == i)) begin
               r_shamt1_vec[i*p_shamt_nbits +: p_shamt_nbits] <= cfg_shamt1;
               r_shamt2_vec[i*p_shamt_nbits +: p_shamt_nbits] <= cfg_shamt2;
            end
         end
      end
   end

   systolic_array_neg_chain_outq #(
      .p_depth (p_out_depth),
      .p_width (data_width)
   ) u_outq (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_enq_val   (r_vpipe[p_chain_lat]),
      .o_enq_rdy   (w_enq_rdy),
      .i_enq_msg   (chain_y_res),
      .o_deq_val   (out_val),
      .i_deq_rdy   (out_rdy),
      .o_deq_msg   (out_msg),
      .o_occupancy (w_occupancy)
   );

   a_no_result_drop: assert property (@(posedge clk) disable iff (reset)
      r_vpipe[p_chain_lat] |-> w_enq_rdy);

endmodule
